// File: rtl/exprnd_pipe_pkg.sv
// Shared definitions for the pipelined exponent rounder.
//  - Rounding-mode encodings
//  - Exponent constants (wrap bias, largest finite exponent) derived from EXP_W
//  - Stage-1 control payload struct
//  - Round-toward-infinity decode helper
package exprnd_pipe_pkg;

   localparam logic [1:0] RM_RZ  = 2'b00;
   localparam logic [1:0] RM_RNE = 2'b01;
   localparam logic [1:0] RM_RU  = 2'b10;
   localparam logic [1:0] RM_RD  = 2'b11;

   // Control bits that travel with each operand through stage 1
   typedef struct packed {
      logic s;       // sign
      logic ovf;     // upstream overflow
      logic ovfen;   // overflow trap enabled
      logic to_inf;  // rounding direction pushes the overflow to infinity
   } ctl_t;

   // Trap-wrap bias: 3 << (exp_w-2), e.g. 1536 for double precision
   function automatic int unsigned alpha_of(input int unsigned exp_w);
      return 32'd3 << (exp_w - 32'd2);
   endfunction

   // Largest finite biased exponent: all ones minus one
   function automatic int unsigned emax_of(input int unsigned exp_w);
      return (32'd1 << exp_w) - 32'd2;
   endfunction

   // Overflow rounds to infinity for RNE, RU on positive, RD on negative
   function automatic logic to_inf_f(input logic [1:0] rm, input logic s);
      logic r;
      case (rm)
         RM_RZ:   r = 1'b0;
         RM_RNE:  r = 1'b1;
         RM_RU:   r = ~s;
         RM_RD:   r = s;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/exprnd_pipe_sel.sv
// Combinational stage-2 result select of the exponent rounder.
// Ports:
//  e_i      biased exponent from the significand rounder
//  ewrap_i  exponent with the trap bias removed (modulo 2^EXP_W)
//  f_i      stored fraction bits (hidden bit already dropped)
//  ovf_i    overflow, ovfen_i trap enable, to_inf_i rounding direction
//  eout_o / fout_o       packed exponent / fraction
//  ovf_o / inx_o         overflow and saturation-inexact flags
module exprnd_pipe_sel
   import exprnd_pipe_pkg::*;
#(
   parameter int unsigned EXP_W  = 11,
   parameter int unsigned FRAC_W = 52
) (
   input  logic [EXP_W-1:0]  e_i,
   input  logic [EXP_W-1:0]  ewrap_i,
   input  logic [FRAC_W-1:0] f_i,
   input  logic              ovf_i,
   input  logic              ovfen_i,
   input  logic              to_inf_i,
   output logic [EXP_W-1:0]  eout_o,
   output logic [FRAC_W-1:0] fout_o,
   output logic              ovf_o,
   output logic              inx_o
);

   localparam logic [EXP_W-1:0] EMAX = EXP_W'(emax_of(EXP_W));

   // Choose passthrough, trap wrap, infinity, or largest finite value
   always_comb begin
      eout_o = e_i;
      fout_o = f_i;
      ovf_o  = 1'b0;
      inx_o  = 1'b0;
      if (!ovf_i) begin
         eout_o = e_i;
         fout_o = f_i;
      end else if (ovfen_i) begin
         eout_o = ewrap_i;
         fout_o = f_i;
         ovf_o  = 1'b1;
      end else if (to_inf_i) begin
         eout_o = '1;
         fout_o = '0;
         ovf_o  = 1'b1;
         inx_o  = 1'b1;
      end else begin
         eout_o = EMAX;
         fout_o = '1;
         ovf_o  = 1'b1;
         inx_o  = 1'b1;
      end
   end

endmodule

// File: rtl/exprnd_pipe.sv
// Two-stage pipelined exponent rounder with valid/ready handshake.
// Stage 1 registers the operand plus the wrapped exponent and rounding
// direction; stage 2 registers the selected packed exponent/fraction and
// per-result flags. Sticky flags accumulate over accepted results.
// Ports:
//  clk, rst                          clock, async active-high reset
//  in_valid/in_ready/in_tag          input handshake and opaque tag
//  s, e3, f3, RM, OVF, OVFen         operand from the significand rounder
//  out_valid/out_ready/out_tag       output handshake and tag
//  out_s, eout, fout, out_ovf, out_inx  packed result and flags
//  flags_clr, sticky_ovf, sticky_inx    sticky flag control/status
module exprnd_pipe
   import exprnd_pipe_pkg::*;
#(
   parameter int unsigned EXP_W  = 11,
   parameter int unsigned FRAC_W = 52,
   parameter int unsigned TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              s,
   input  logic [EXP_W-1:0]  e3,
   input  logic [FRAC_W:0]   f3,
   input  logic [1:0]        RM,
   input  logic              OVF,
   input  logic              OVFen,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_s,
   output logic [EXP_W-1:0]  eout,
   output logic [FRAC_W-1:0] fout,
   output logic              out_ovf,
   output logic              out_inx,
   input  logic              flags_clr,
   output logic              sticky_ovf,
   output logic              sticky_inx
);

   localparam logic [EXP_W-1:0] ALPHA = EXP_W'(alpha_of(EXP_W));

   // stage 1
   logic              v1_q, v1_d;
   logic [TAG_W-1:0]  tag1_q;
   ctl_t              ctl1_q;
   logic [EXP_W-1:0]  e1_q;
   logic [EXP_W-1:0]  ewrap1_q;
   logic [FRAC_W:0]   f1_q;
   // stage 2
   logic              v2_q, v2_d;
   logic [TAG_W-1:0]  tag2_q;
   logic              s2_q;
   logic [EXP_W-1:0]  e2_q;
   logic [FRAC_W-1:0] f2_q;
   logic              ovf2_q, inx2_q;
   // control
   logic              rdy_q;
   logic              sticky_ovf_q, sticky_ovf_d;
   logic              sticky_inx_q, sticky_inx_d;
   logic              ld1_s, ld2_s, in_fire_s, out_fire_s;
   ctl_t              ctl_in_s;
   logic [EXP_W-1:0]  sel_e_s;
   logic [FRAC_W-1:0] sel_f_s;
   logic              sel_ovf_s, sel_inx_s;

   // Handshake, valid and sticky next-state
   always_comb begin
      ld2_s      = !v2_q || out_ready;
      ld1_s      = !v1_q || ld2_s;
      // rdy_q keeps the input closed until the first edge after reset release
      in_ready   = rdy_q && ld1_s;
      in_fire_s  = in_valid && in_ready;
      out_fire_s = v2_q && out_ready;
      v1_d       = ld1_s ? in_fire_s : v1_q;
      v2_d       = ld2_s ? v1_q : v2_q;
      // A result transferring in the clearing cycle still sets the flag
      if (flags_clr) begin
         sticky_ovf_d = out_fire_s && ovf2_q;
         sticky_inx_d = out_fire_s && inx2_q;
      end else begin
         sticky_ovf_d = sticky_ovf_q || (out_fire_s && ovf2_q);
         sticky_inx_d = sticky_inx_q || (out_fire_s && inx2_q);
      end
   end

   // Stage-1 control payload decode
   always_comb begin
      ctl_in_s.s      = s;
      ctl_in_s.ovf    = OVF;
      ctl_in_s.ovfen  = OVFen;
      ctl_in_s.to_inf = to_inf_f(RM, s);
   end

   exprnd_pipe_sel #(
      .EXP_W  (EXP_W),
      .FRAC_W (FRAC_W)
   ) u_sel (
      .e_i      (e1_q),
      .ewrap_i  (ewrap1_q),
      .f_i      (f1_q[FRAC_W-1:0]),
      .ovf_i    (ctl1_q.ovf),
      .ovfen_i  (ctl1_q.ovfen),
      .to_inf_i (ctl1_q.to_inf),
      .eout_o   (sel_e_s),
      .fout_o   (sel_f_s),
      .ovf_o    (sel_ovf_s),
      .inx_o    (sel_inx_s)
   );

   // Valid bits, ready enable and sticky flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q         <= 1'b0;
         v2_q         <= 1'b0;
         rdy_q        <= 1'b0;
         sticky_ovf_q <= 1'b0;
         sticky_inx_q <= 1'b0;
      end else begin
         v1_q         <= v1_d;
         v2_q         <= v2_d;
         rdy_q        <= 1'b1;
         sticky_ovf_q <= sticky_ovf_d;
         sticky_inx_q <= sticky_inx_d;
      end
   end

   // Stage-1 payload: loads only on an input transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag1_q   <= '0;
         ctl1_q   <= '0;
         e1_q     <= '0;
         ewrap1_q <= '0;
         f1_q     <= '0;
      end else if (in_fire_s) begin
         tag1_q   <= in_tag;
         ctl1_q   <= ctl_in_s;
         e1_q     <= e3;
         ewrap1_q <= e3 - ALPHA;   // modulo 2^EXP_W, borrow ignored
         f1_q     <= f3;
      end else begin
         tag1_q   <= tag1_q;
         ctl1_q   <= ctl1_q;
         e1_q     <= e1_q;
         ewrap1_q <= ewrap1_q;
         f1_q     <= f1_q;
      end
   end

   // Stage-2 payload: held while stalled so outputs stay stable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag2_q <= '0;
         s2_q   <= 1'b0;
         e2_q   <= '0;
         f2_q   <= '0;
         ovf2_q <= 1'b0;
         inx2_q <= 1'b0;
      end else if (ld2_s && v1_q) begin
         tag2_q <= tag1_q;
         s2_q   <= ctl1_q.s;
         e2_q   <= sel_e_s;
         f2_q   <= sel_f_s;
         ovf2_q <= sel_ovf_s;
         inx2_q <= sel_inx_s;
      end else begin
         tag2_q <= tag2_q;
         s2_q   <= s2_q;
         e2_q   <= e2_q;
         f2_q   <= f2_q;
         ovf2_q <= ovf2_q;
         inx2_q <= inx2_q;
      end
   end

   assign out_valid  = v2_q;
   assign out_tag    = tag2_q;
   assign out_s      = s2_q;
   assign eout       = e2_q;
   assign fout       = f2_q;
   assign out_ovf    = ovf2_q;
   assign out_inx    = inx2_q;
   assign sticky_ovf = sticky_ovf_q;
   assign sticky_inx = sticky_inx_q;

endmodule
